// File: rtl/div_radix2_pkg.sv
// Shared opcode layout, FSM states and helpers for the radix-2 divider.
// The same opcode constants are used by decode and md.
package div_radix2_pkg;

   localparam int DIV_OP_UNSIGNED = 0;
   localparam int DIV_OP_REM      = 1;
   localparam int DIV_OP_WORD     = 2;

   localparam logic [2:0] OP_DIV   = 3'b000;
   localparam logic [2:0] OP_DIVU  = 3'b001;
   localparam logic [2:0] OP_REM   = 3'b010;
   localparam logic [2:0] OP_REMU  = 3'b011;
   localparam logic [2:0] OP_DIVW  = 3'b100;
   localparam logic [2:0] OP_DIVUW = 3'b101;
   localparam logic [2:0] OP_REMW  = 3'b110;
   localparam logic [2:0] OP_REMUW = 3'b111;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PREP,
      ST_ITER,
      ST_FIX,
      ST_DONE
   } state_t;

   function automatic logic [63:0] sext32(input logic [31:0] v);
      return {{32{v[31]}}, v};
   endfunction

endpackage

// File: rtl/div_radix2_if.sv
// Request/response bundle between md's divider slot and the divider.
interface div_radix2_if;
   logic [63:0] operand1;
   logic [63:0] operand2;
   logic [2:0]  div_op;
   logic        req_valid;
   logic        req_ready;
   logic        resp_valid;
   logic [63:0] resp_result;

   modport master (
      output operand1, operand2, div_op, req_valid,
      input  req_ready, resp_valid, resp_result
   );

   modport slave (
      input  operand1, operand2, div_op, req_valid,
      output req_ready, resp_valid, resp_result
   );
endinterface

// File: rtl/div_radix2.sv
// Iterative restoring divider for RV64M DIV/REM and W variants, one quotient bit per cycle.
// Latency: 67 cycles (64-bit), 35 (W), 2 for divide-by-zero/overflow; accepts only in IDLE.
module div_radix2
   import div_radix2_pkg::*;
#(
   parameter int XLEN = 64
) (
   input logic        clk,
   input logic        rst,
   div_radix2_if.slave bus
);

   state_t state, state_nxt;

   logic [XLEN-1:0] a_q, b_q;
   logic [2:0]      op_q;
   logic [XLEN-1:0] quo, rem, dvs, result_q;
   logic [6:0]      cnt;
   logic            q_neg, r_neg;

   // Operand conditioning, evaluated during PREP from the latched request
   logic            is_w, is_s;
   logic [XLEN-1:0] a_ext, b_ext, a_abs, b_abs, special_val;
   logic            a_neg, b_neg, div_zero, overflow;

   always_comb begin
      is_w  = op_q[DIV_OP_WORD];
      is_s  = !op_q[DIV_OP_UNSIGNED];
      a_ext = is_w ? (is_s ? sext32(a_q[31:0]) : {32'h0, a_q[31:0]}) : a_q;
      b_ext = is_w ? (is_s ? sext32(b_q[31:0]) : {32'h0, b_q[31:0]}) : b_q;
      a_neg = is_s && a_ext[XLEN-1];
      b_neg = is_s && b_ext[XLEN-1];
      a_abs = a_neg ? -a_ext : a_ext;
      b_abs = b_neg ? -b_ext : b_ext;
      div_zero = (b_ext == '0);
      overflow = is_s && (b_ext == '1) &&
                 (a_ext == (is_w ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000));
      if (div_zero)
         special_val = op_q[DIV_OP_REM] ? (is_w ? sext32(a_q[31:0]) : a_q) : '1;
      else
         special_val = op_q[DIV_OP_REM] ? '0 : a_ext;
   end

   // Shift-and-trial-subtract step; bit XLEN of diff is the borrow
   logic [XLEN:0]   rem_sh, diff;

   always_comb begin
      rem_sh = {rem, quo[XLEN-1]};
      diff   = rem_sh - {1'b0, dvs};
   end

   logic [XLEN-1:0] q_fix, r_fix, sel, fix_val;

   always_comb begin
      q_fix   = q_neg ? -quo : quo;
      r_fix   = r_neg ? -rem : rem;
      sel     = op_q[DIV_OP_REM] ? r_fix : q_fix;
      fix_val = op_q[DIV_OP_WORD] ? sext32(sel[31:0]) : sel;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (bus.req_valid) state_nxt = ST_PREP;
         ST_PREP: state_nxt = (div_zero || overflow) ? ST_DONE : ST_ITER;
         ST_ITER: if (cnt == 7'd1) state_nxt = ST_FIX;
         ST_FIX:  state_nxt = ST_DONE;
         ST_DONE: state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_q      <= '0;
         b_q      <= '0;
         op_q     <= '0;
         quo      <= '0;
         rem      <= '0;
         dvs      <= '0;
         cnt      <= '0;
         q_neg    <= 1'b0;
         r_neg    <= 1'b0;
         result_q <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (bus.req_valid) begin
                  a_q  <= bus.operand1;
                  b_q  <= bus.operand2;
                  op_q <= bus.div_op;
               end
            end
            ST_PREP: begin
               if (div_zero || overflow) begin
                  result_q <= special_val;
               end else begin
                  // W dividends start in the top half so the MSB-first shift sees them first
                  quo   <= is_w ? {a_abs[31:0], 32'h0} : a_abs;
                  rem   <= '0;
                  dvs   <= b_abs;
                  cnt   <= is_w ? 7'd32 : 7'd64;
                  q_neg <= a_neg ^ b_neg;
                  r_neg <= a_neg;
               end
            end
            ST_ITER: begin
               if (!diff[XLEN]) begin
                  rem <= diff[XLEN-1:0];
                  quo <= {quo[XLEN-2:0], 1'b1};
               end else begin
                  rem <= rem_sh[XLEN-1:0];
                  quo <= {quo[XLEN-2:0], 1'b0};
               end
               cnt <= cnt - 7'd1;
            end
            ST_FIX: result_q <= fix_val;
            default: ;
         endcase
      end
   end

   assign bus.req_ready   = (state == ST_IDLE);
   assign bus.resp_valid  = (state == ST_DONE);
   assign bus.resp_result = result_q;

endmodule
